// File: rtl/tug_round_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tug_round_ctrl_if                                                          |
// | Playfield-side bundle of the tug-of-war round controller.                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface tug_round_ctrl_if #(
    parameter int SCORE_W = 3
) ();
    logic               keyL_raw;
    logic               keyR_raw;
    logic               edgeL;
    logic               edgeR;
    logic               pressL;
    logic               pressR;
    logic               resetRound;
    logic [SCORE_W-1:0] scoreL;
    logic [SCORE_W-1:0] scoreR;
    logic               winnerL;
    logic               winnerR;

    // master: buttons and playfield; slave: the round controller
    modport master (
        output keyL_raw, keyR_raw, edgeL, edgeR,
        input  pressL, pressR, resetRound, scoreL, scoreR, winnerL, winnerR
    );

    modport slave (
        input  keyL_raw, keyR_raw, edgeL, edgeR,
        output pressL, pressR, resetRound, scoreL, scoreR, winnerL, winnerR
    );
endinterface
`default_nettype wire

// File: rtl/tug_round_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tug_round_ctrl                                                             |
// | Conditions player keys, detects round wins, keeps scores, ends the match.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tug_round_ctrl #(
    parameter int SCORE_W     = 3,
    parameter int MAX_SCORE   = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    tug_round_ctrl_if.slave bus
);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] MAX_S     = SCORE_W'(MAX_SCORE);

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_HOLD = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    logic keyL_meta_q, keyL_sync_q, keyL_dly_q, pulseL_q;
    logic keyR_meta_q, keyR_sync_q, keyR_dly_q, pulseR_q;

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  cnt_q, cnt_d;
    logic [SCORE_W-1:0] scoreL_q, scoreL_d, scoreR_q, scoreR_d;
    logic               winnerL_q, winnerL_d, winnerR_q, winnerR_d;

    logic               pressL, pressR, winL, winR;
    logic [SCORE_W-1:0] incL, incR;

    // Edge detectors run in every state so a key held through HOLD never fires on PLAY entry
    always_ff @(posedge clk) begin
        if (reset) begin
            keyL_meta_q <= 1'b0;
            keyL_sync_q <= 1'b0;
            keyL_dly_q  <= 1'b0;
            pulseL_q    <= 1'b0;
            keyR_meta_q <= 1'b0;
            keyR_sync_q <= 1'b0;
            keyR_dly_q  <= 1'b0;
            pulseR_q    <= 1'b0;
        end else begin
            keyL_meta_q <= bus.keyL_raw;
            keyL_sync_q <= keyL_meta_q;
            keyL_dly_q  <= keyL_sync_q;
            pulseL_q    <= keyL_sync_q & ~keyL_dly_q;
            keyR_meta_q <= bus.keyR_raw;
            keyR_sync_q <= keyR_meta_q;
            keyR_dly_q  <= keyR_sync_q;
            pulseR_q    <= keyR_sync_q & ~keyR_dly_q;
        end
    end

    assign pressL = pulseL_q & (state_q == ST_PLAY);
    assign pressR = pulseR_q & (state_q == ST_PLAY);
    assign winL   = pressL & ~pressR & bus.edgeL;
    assign winR   = pressR & ~pressL & bus.edgeR;
    assign incL   = scoreL_q + 1'b1;
    assign incR   = scoreR_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_HOLD;
            cnt_q     <= HOLD_LOAD;
            scoreL_q  <= '0;
            scoreR_q  <= '0;
            winnerL_q <= 1'b0;
            winnerR_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            scoreL_q  <= scoreL_d;
            scoreR_q  <= scoreR_d;
            winnerL_q <= winnerL_d;
            winnerR_q <= winnerR_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        scoreL_d  = scoreL_q;
        scoreR_d  = scoreR_q;
        winnerL_d = winnerL_q;
        winnerR_d = winnerR_q;
        case (state_q)
            ST_PLAY: begin
                if (winL) begin
                    scoreL_d = incL;
                    if (incL == MAX_S) begin
                        state_d   = ST_OVER;
                        winnerL_d = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end else if (winR) begin
                    scoreR_d = incR;
                    if (incR == MAX_S) begin
                        state_d   = ST_OVER;
                        winnerR_d = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_PLAY;
                end else begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end
            end
            ST_OVER: begin
                state_d = ST_OVER;
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = HOLD_LOAD;
            end
        endcase
    end

    assign bus.pressL     = pressL;
    assign bus.pressR     = pressR;
    assign bus.resetRound = (state_q == ST_HOLD);
    assign bus.scoreL     = scoreL_q;
    assign bus.scoreR     = scoreR_q;
    assign bus.winnerL    = winnerL_q;
    assign bus.winnerR    = winnerR_q;
endmodule
`default_nettype wire

// File: tb/tb_tug_round_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tug_round_ctrl                                                          |
// | Directed bench for the tug-of-war round controller.                        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_tug_round_ctrl;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    tug_round_ctrl_if #(.SCORE_W(3)) bus ();

    tug_round_ctrl #(
        .SCORE_W     (3),
        .MAX_SCORE   (7),
        .HOLD_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle raw press; returns on the cycle the press pulse is visible
    task automatic key_pulse(input bit left);
        if (left) bus.keyL_raw = 1'b1; else bus.keyR_raw = 1'b1;
        tick();
        bus.keyL_raw = 1'b0;
        bus.keyR_raw = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int pulses;
        int pos;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        bus.keyL_raw = 1'b0;
        bus.keyR_raw = 1'b0;
        bus.edgeL    = 1'b0;
        bus.edgeR    = 1'b0;

        // 1: reset state and power-up recentre
        do_reset();
        check("rst_scoreL", 32'(bus.scoreL), 0);
        check("rst_scoreR", 32'(bus.scoreR), 0);
        check("rst_winner", {30'd0, bus.winnerL, bus.winnerR}, 0);
        check("rst_press",  {30'd0, bus.pressL, bus.pressR}, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_rr_hold%0d", i), 32'(bus.resetRound), 1);
            tick();
        end
        check("t1_rr_play", 32'(bus.resetRound), 0);

        // 2: held key, no edge -> single pulse 3 cycles after rise
        bus.keyL_raw = 1'b1;
        pulses = 0;
        pos    = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (bus.pressL) begin
                pulses++;
                pos = i;
            end
        end
        bus.keyL_raw = 1'b0;
        check("t2_pulses", 32'(pulses), 1);
        check("t2_latency", 32'(pos), 3);
        check("t2_scoreL", 32'(bus.scoreL), 0);
        tick();
        tick();
        tick();

        // 3: left win at edge
        bus.edgeL = 1'b1;
        key_pulse(1'b1);
        check("t3_pressL", 32'(bus.pressL), 1);
        tick();
        bus.edgeL = 1'b0;
        check("t3_scoreL", 32'(bus.scoreL), 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_rr%0d", i), 32'(bus.resetRound), 1);
            tick();
        end
        check("t3_rr_play", 32'(bus.resetRound), 0);

        // 4: simultaneous presses cancel
        bus.edgeL = 1'b1;
        bus.edgeR = 1'b1;
        bus.keyL_raw = 1'b1;
        bus.keyR_raw = 1'b1;
        tick();
        bus.keyL_raw = 1'b0;
        bus.keyR_raw = 1'b0;
        tick();
        tick();
        check("t4_both", {30'd0, bus.pressL, bus.pressR}, 3);
        tick();
        check("t4_scores", {16'(bus.scoreL), 16'(bus.scoreR)}, {16'd1, 16'd0});
        check("t4_rr", 32'(bus.resetRound), 0);
        bus.edgeL = 1'b0;

        // 5: seven right wins end the match
        for (int k = 1; k <= 7; k++) begin
            key_pulse(1'b0);
            tick();
            check($sformatf("t5_scoreR%0d", k), 32'(bus.scoreR), 32'(k));
            if (k < 7) begin
                check($sformatf("t5_rr%0d", k), 32'(bus.resetRound), 1);
                for (int i = 0; i < 4; i++) tick();
            end
        end
        check("t5_winner", {30'd0, bus.winnerL, bus.winnerR}, 1);
        check("t5_rr_over", 32'(bus.resetRound), 0);
        key_pulse(1'b0);
        check("t5_press_over", 32'(bus.pressR), 0);
        tick();
        check("t5_frozen", {16'(bus.scoreL), 16'(bus.scoreR)}, {16'd1, 16'd7});
        bus.edgeR = 1'b0;
        do_reset();
        check("t5_rst_scores", {16'(bus.scoreL), 16'(bus.scoreR)}, 0);
        check("t5_rst_winner", {30'd0, bus.winnerL, bus.winnerR}, 0);
        check("t5_rst_rr", 32'(bus.resetRound), 1);
        for (int i = 0; i < 4; i++) tick();

        // 6: reset during HOLD, key held through the new HOLD
        bus.edgeL = 1'b1;
        key_pulse(1'b1);
        tick();
        check("t6_scoreL", 32'(bus.scoreL), 1);
        bus.keyL_raw = 1'b1;
        tick();
        do_reset();
        check("t6_rst_scoreL", 32'(bus.scoreL), 0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t6_rr%0d", i), 32'(bus.resetRound), 1);
            if (bus.pressL) pulses++;
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            if (bus.pressL) pulses++;
            tick();
        end
        check("t6_rr_play", 32'(bus.resetRound), 0);
        check("t6_no_pulse", 32'(pulses), 0);
        check("t6_scoreL_end", 32'(bus.scoreL), 0);
        bus.keyL_raw = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
